// File: rtl/fd_hazard_controller_if.sv
// Hazard-control bundle between the decode/execute stages and the F/D hazard controller.
// The controller attaches to the slave modport and the pipeline side to the master modport.
interface fd_hazard_if #(
  parameter int unsigned REG_W  = 4,
  parameter int unsigned VCNT_W = 4,
  parameter int unsigned PERF_W = 16
);
  logic [REG_W-1:0]  Rs1D;
  logic [REG_W-1:0]  Rs2D;
  logic [REG_W-1:0]  RdE;
  logic              MemtoRegE;
  logic              PCSrcE;
  logic              VecStartE;
  logic [VCNT_W-1:0] VecCyclesE;
  logic              StallF;
  logic              EnD;
  logic              ClrD;
  logic              StallE;
  logic              FlushE;
  logic              VecBusy;
  logic [PERF_W-1:0] StallCnt;
  logic [PERF_W-1:0] FlushCnt;

  modport master (
    output Rs1D, Rs2D, RdE, MemtoRegE, PCSrcE, VecStartE, VecCyclesE,
    input  StallF, EnD, ClrD, StallE, FlushE, VecBusy, StallCnt, FlushCnt
  );

  modport slave (
    input  Rs1D, Rs2D, RdE, MemtoRegE, PCSrcE, VecStartE, VecCyclesE,
    output StallF, EnD, ClrD, StallE, FlushE, VecBusy, StallCnt, FlushCnt
  );
endinterface

// File: rtl/fd_hazard_controller.sv
// Fetch/Decode hazard controller: load-use stalls, branch flushes, multi-cycle vector holds,
// plus saturating stall/flush event counters for performance debug.
module fd_hazard_controller #(
  parameter int unsigned REG_W  = 4,
  parameter int unsigned VCNT_W = 4,
  parameter int unsigned PERF_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  fd_hazard_if.slave  hz
);

  typedef enum logic [0:0] {RUN = 1'b0, VBUSY = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [VCNT_W-1:0]  vcnt_q, vcnt_d;
  logic [PERF_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic stall_f_c, en_d_c, clr_d_c, stall_e_c, flush_e_c, vec_busy_c;
  logic load_use_c;

  assign load_use_c = hz.MemtoRegE && (hz.RdE != REG_W'(0)) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  // Strobes are zero-latency; next state and counters are resolved alongside them.
  always_comb begin
    stall_f_c   = 1'b0;
    en_d_c      = 1'b1;
    clr_d_c     = 1'b0;
    stall_e_c   = 1'b0;
    flush_e_c   = 1'b0;
    vec_busy_c  = 1'b0;
    state_d     = state_q;
    vcnt_d      = vcnt_q;

    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (hz.PCSrcE) begin
            clr_d_c   = 1'b1;
            flush_e_c = 1'b1;
          end else if (hz.VecStartE && (hz.VecCyclesE >= VCNT_W'(2))) begin
            stall_f_c = 1'b1;
            en_d_c    = 1'b0;
            stall_e_c = 1'b1;
            // The start cycle is the first of N-1 stalls, so VBUSY lasts N-2 cycles.
            if (hz.VecCyclesE >= VCNT_W'(3)) begin
              state_d = VBUSY;
              vcnt_d  = hz.VecCyclesE - VCNT_W'(3);
            end
          end else if (load_use_c) begin
            stall_f_c = 1'b1;
            en_d_c    = 1'b0;
            flush_e_c = 1'b1;
          end
        end
        VBUSY: begin
          stall_f_c  = 1'b1;
          en_d_c     = 1'b0;
          stall_e_c  = 1'b1;
          vec_busy_c = 1'b1;
          if (vcnt_q == VCNT_W'(0)) begin
            state_d = RUN;
          end else begin
            vcnt_d = vcnt_q - VCNT_W'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f_c && (stall_cnt_q != {PERF_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
    if (clr_d_c && (flush_cnt_q != {PERF_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      vcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      vcnt_q      <= vcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.StallF   = stall_f_c;
  assign hz.EnD      = en_d_c;
  assign hz.ClrD     = clr_d_c;
  assign hz.StallE   = stall_e_c;
  assign hz.FlushE   = flush_e_c;
  assign hz.VecBusy  = vec_busy_c;
  assign hz.StallCnt = stall_cnt_q;
  assign hz.FlushCnt = flush_cnt_q;

endmodule
